// File: rtl/cavlc_pkg.sv
// Shared widths, state encoding and VLC field sizes for the CAVLC bitstream path.
package cavlc_pkg;

   localparam int unsigned MAX_LEN  = 16;  // widest accepted code
   localparam int unsigned LEN_W    = 5;   // holds 0..MAX_LEN
   localparam int unsigned WORD_W   = 32;  // output word width
   localparam int unsigned ACC_W    = 48;  // 31 residual + 16 incoming bits fit
   localparam int unsigned CNT_W    = 6;   // valid-bit count in the accumulator
   localparam int unsigned BITS_W   = 6;   // outBits width (1..32)
   localparam int unsigned BCNT_W   = 32;  // running bit counter

   // coeff_token lookup fields shared with the VLC tables
   localparam int unsigned CT_LEN_W = 4;   // coded as length-1
   localparam int unsigned CT_VAL_W = 16;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/cavlc_code_align.sv
// Masks a right-aligned code to its length and places it just below the
// currently valid bits of the MSB-aligned accumulator.
module cavlc_code_align
   import cavlc_pkg::*;
(
   input  logic [MAX_LEN-1:0] i_bits,
   input  logic [LEN_W-1:0]   i_len,   // already saturated to MAX_LEN
   input  logic [CNT_W-1:0]   i_cnt,
   output logic [ACC_W-1:0]   o_aligned
);

   logic [MAX_LEN-1:0] w_masked;
   logic [CNT_W-1:0]   w_shift;

   // Drop bits above i_len, then shift the code up to sit after i_cnt valid bits
   always_comb begin
      w_masked  = i_bits & ~({MAX_LEN{1'b1}} << i_len);
      w_shift   = CNT_W'(ACC_W) - i_cnt - CNT_W'(i_len);
      o_aligned = ACC_W'(w_masked) << w_shift;
   end

endmodule

// File: rtl/cavlc_bit_packer.sv
// Concatenates variable-length codes MSB-first and emits 32-bit words, with a
// flush that pads and marks the final partial word.
module cavlc_bit_packer
   import cavlc_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               inValid,
   output logic               inReady,
   input  logic [LEN_W-1:0]   inLen,
   input  logic [MAX_LEN-1:0] inBits,
   input  logic               inFlush,
   output logic               outValid,
   input  logic               outReady,
   output logic [WORD_W-1:0]  outWord,
   output logic               outLast,
   output logic [BITS_W-1:0]  outBits,
   output logic               flushDone,
   output logic [BCNT_W-1:0]  bitCount
);

   localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);

   state_t             r_st;
   state_t             w_st_next;
   logic [ACC_W-1:0]   r_acc;
   logic [ACC_W-1:0]   w_aligned;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_sum;
   logic [LEN_W-1:0]   w_len;
   logic [BCNT_W-1:0]  r_bit_count;
   logic               r_flush_done;
   logic               w_flush_done_next;
   logic               w_in_ready;
   logic               w_accept;
   logic               w_out_valid;
   logic               w_out_last;
   logic               w_emit;
   logic [WORD_W-1:0]  w_out_word;
   logic [WORD_W-1:0]  w_tail_mask;
   logic [BITS_W-1:0]  w_out_bits;

   // Over-long codes saturate to MAX_LEN
   always_comb begin
      w_len     = (inLen > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : inLen;
      w_cnt_sum = r_cnt + CNT_W'(w_len);
   end

   cavlc_code_align u_align (
      .i_bits    (inBits),
      .i_len     (w_len),
      .i_cnt     (r_cnt),
      .o_aligned (w_aligned)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_st <= RUN;
      else        r_st <= w_st_next;
   end

   // Next state, handshakes and output word formation
   always_comb begin
      w_st_next         = r_st;
      w_in_ready        = 1'b0;
      w_accept          = 1'b0;
      w_out_valid       = 1'b0;
      w_out_last        = 1'b0;
      w_emit            = 1'b0;
      w_flush_done_next = 1'b0;
      w_out_word        = '0;
      w_out_bits        = '0;
      w_tail_mask       = ~({WORD_W{1'b1}} >> r_cnt);

      case (r_st)
         RUN: begin
            w_in_ready  = rst_n && (r_cnt < WORD_CNT);
            w_out_valid = rst_n && (r_cnt >= WORD_CNT);
            w_accept    = inValid && w_in_ready;
            // A flush that leaves nothing buffered completes immediately
            if (w_accept && inFlush) begin
               if (w_cnt_sum == '0) w_flush_done_next = 1'b1;
               else                 w_st_next         = FLUSH;
            end
         end
         FLUSH: begin
            if (r_cnt == '0) begin
               w_flush_done_next = rst_n;
               w_st_next         = RUN;
            end else begin
               w_out_valid = rst_n;
               w_out_last  = (r_cnt <= WORD_CNT);
            end
         end
         default: w_st_next = RUN;
      endcase

      w_emit = w_out_valid && outReady;
      if (w_emit && w_out_last) begin
         w_flush_done_next = 1'b1;
         w_st_next         = RUN;
      end

      if (w_out_valid) begin
         w_out_word = w_out_last ? (r_acc[ACC_W-1 -: WORD_W] & w_tail_mask)
                                 : r_acc[ACC_W-1 -: WORD_W];
         w_out_bits = w_out_last ? BITS_W'(r_cnt) : BITS_W'(WORD_W);
      end
   end

   // Accumulator, bit counters and flush-done pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc        <= '0;
         r_cnt        <= '0;
         r_bit_count  <= '0;
         r_flush_done <= 1'b0;
      end else begin
         r_flush_done <= w_flush_done_next;
         if (w_accept) begin
            r_acc       <= r_acc | w_aligned;
            r_cnt       <= w_cnt_sum;
            r_bit_count <= r_bit_count + BCNT_W'(w_len);
         end else if (w_emit) begin
            if (w_out_last) begin
               r_acc <= '0;
               r_cnt <= '0;
            end else begin
               r_acc <= r_acc << WORD_W;
               r_cnt <= r_cnt - WORD_CNT;
            end
         end
      end
   end

   assign inReady   = w_in_ready;
   assign outValid  = w_out_valid;
   assign outWord   = w_out_word;
   assign outLast   = w_out_last;
   assign outBits   = w_out_bits;
   assign flushDone = r_flush_done;
   assign bitCount  = r_bit_count;

endmodule

// File: tb/tb_cavlc_bit_packer.sv
// Bench for cavlc_bit_packer: directed scenarios plus random traffic against a
// bit-queue reference model.
module tb_cavlc_bit_packer;
   import cavlc_pkg::*;

   logic               clk      = 1'b0;
   logic               rst_n    = 1'b0;
   logic               inValid  = 1'b0;
   logic [LEN_W-1:0]   inLen    = '0;
   logic [MAX_LEN-1:0] inBits   = '0;
   logic               inFlush  = 1'b0;
   logic               outReady = 1'b0;
   logic               inReady;
   logic               outValid;
   logic [WORD_W-1:0]  outWord;
   logic               outLast;
   logic [BITS_W-1:0]  outBits;
   logic               flushDone;
   logic [BCNT_W-1:0]  bitCount;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cavlc_bit_packer dut (
      .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
      .inLen(inLen), .inBits(inBits), .inFlush(inFlush),
      .outValid(outValid), .outReady(outReady), .outWord(outWord),
      .outLast(outLast), .outBits(outBits), .flushDone(flushDone),
      .bitCount(bitCount)
   );

   // Reference model: the stream as a queue of bits, first bit at the front
   bit          mq[$];
   bit          m_flush    = 1'b0;
   logic [31:0] m_bitcount = '0;
   logic        m_fd       = 1'b0;

   function automatic logic m_ready();
      return !m_flush && (mq.size() < 32);
   endfunction
   function automatic logic m_valid();
      return m_flush ? (mq.size() != 0) : (mq.size() >= 32);
   endfunction
   function automatic logic m_last();
      return m_flush && (mq.size() > 0) && (mq.size() <= 32);
   endfunction
   function automatic logic [5:0] m_bits();
      return m_last() ? 6'(mq.size()) : 6'd32;
   endfunction
   function automatic logic [31:0] m_word();
      logic [31:0] w = '0;
      for (int i = 0; i < 32 && i < mq.size(); i++) w[31-i] = mq[i];
      return w;
   endfunction

   always @(posedge clk) begin : ref_model
      int len;
      bit do_acc, do_emit, was_last, fd_n;
      if (!rst_n) begin
         mq.delete();
         m_flush    = 1'b0;
         m_bitcount = '0;
         m_fd       = 1'b0;
      end else begin
         do_acc   = inValid && m_ready();
         do_emit  = m_valid() && outReady;
         was_last = m_last();
         fd_n     = 1'b0;
         if (do_acc) begin
            len = (int'(inLen) > 16) ? 16 : int'(inLen);
            for (int i = len - 1; i >= 0; i--) mq.push_back(inBits[i]);
            m_bitcount = m_bitcount + 32'(len);
            if (inFlush) begin
               if (mq.size() == 0) fd_n = 1'b1;
               else                m_flush = 1'b1;
            end
         end else if (do_emit) begin
            if (was_last) begin
               mq.delete();
               m_flush = 1'b0;
               fd_n    = 1'b1;
            end else begin
               repeat (32) void'(mq.pop_front());
            end
         end
         m_fd = fd_n;
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input int len, input logic [15:0] bits, input logic fl);
      inValid = v;
      inLen   = LEN_W'(len);
      inBits  = bits;
      inFlush = fl;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 8, 16'hFFFF, 1'b0);
      outReady = 1'b1;
      repeat (3) tick();
      n_vec++; if (inReady !== 1'b0) begin n_err++; $display("FAIL reset_inReady: got %b want 0", inReady); end
      n_vec++; if (outValid !== 1'b0) begin n_err++; $display("FAIL reset_outValid: got %b want 0", outValid); end
      n_vec++; if (outWord !== 32'h0) begin n_err++; $display("FAIL reset_outWord: got %h want 0", outWord); end
      n_vec++; if (outBits !== 6'd0 || outLast !== 1'b0) begin n_err++; $display("FAIL reset_bits_last: got %0d/%b want 0/0", outBits, outLast); end
      n_vec++; if (bitCount !== 32'd0 || flushDone !== 1'b0) begin n_err++; $display("FAIL reset_counters: got %0d/%b want 0/0", bitCount, flushDone); end
      drive(1'b0, 0, 16'h0, 1'b0);
      rst_n = 1'b1;
      #1;
      n_vec++; if (inReady !== 1'b1) begin n_err++; $display("FAIL reset_release_inReady: got %b want 1", inReady); end
   endtask

   task automatic test_eight_beats();
      outReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4, 16'h000F, 1'b0);
         #1;
         n_vec++; if (inReady !== 1'b1) begin n_err++; $display("FAIL eight_inReady beat %0d: got %b want 1", i, inReady); end
         tick();
      end
      drive(1'b0, 0, 16'h0, 1'b0);
      n_vec++; if (outValid !== 1'b1 || outWord !== 32'hFFFFFFFF) begin n_err++; $display("FAIL eight_word: got v=%b %h want v=1 ffffffff", outValid, outWord); end
      n_vec++; if (outLast !== 1'b0 || outBits !== 6'd32 || inReady !== 1'b0) begin n_err++; $display("FAIL eight_flags: got last=%b bits=%0d rdy=%b want 0/32/0", outLast, outBits, inReady); end
      tick();
      n_vec++; if (outValid !== 1'b0 || inReady !== 1'b1) begin n_err++; $display("FAIL eight_drain: got v=%b rdy=%b want 0/1", outValid, inReady); end
      n_vec++; if (bitCount !== 32'd32) begin n_err++; $display("FAIL eight_bitCount: got %0d want 32", bitCount); end
   endtask

   task automatic test_flush_single();
      outReady = 1'b0;
      drive(1'b1, 6, 16'h000F, 1'b1);
      tick();
      drive(1'b0, 0, 16'h0, 1'b0);
      n_vec++; if (outValid !== 1'b1 || outWord !== 32'h3C000000) begin n_err++; $display("FAIL flush1_word: got v=%b %h want v=1 3c000000", outValid, outWord); end
      n_vec++; if (outBits !== 6'd6 || outLast !== 1'b1 || inReady !== 1'b0) begin n_err++; $display("FAIL flush1_flags: got bits=%0d last=%b rdy=%b want 6/1/0", outBits, outLast, inReady); end
      outReady = 1'b1;
      tick();
      n_vec++; if (flushDone !== 1'b1 || outValid !== 1'b0) begin n_err++; $display("FAIL flush1_done: got fd=%b v=%b want 1/0", flushDone, outValid); end
      tick();
      n_vec++; if (flushDone !== 1'b0 || inReady !== 1'b1) begin n_err++; $display("FAIL flush1_after: got fd=%b rdy=%b want 0/1", flushDone, inReady); end
   endtask

   task automatic test_three_beats();
      outReady = 1'b0;
      drive(1'b1, 16, 16'hFFFF, 1'b0); tick();
      drive(1'b1, 16, 16'h0001, 1'b0); tick();
      drive(1'b1, 4, 16'h000A, 1'b1);
      n_vec++; if (outValid !== 1'b1 || outWord !== 32'hFFFF0001 || outLast !== 1'b0) begin n_err++; $display("FAIL three_word1: got v=%b %h last=%b want 1 ffff0001 0", outValid, outWord, outLast); end
      n_vec++; if (inReady !== 1'b0) begin n_err++; $display("FAIL three_full_inReady: got %b want 0", inReady); end
      outReady = 1'b1;
      tick();
      n_vec++; if (outValid !== 1'b0 || inReady !== 1'b1) begin n_err++; $display("FAIL three_resume: got v=%b rdy=%b want 0/1", outValid, inReady); end
      tick();
      drive(1'b0, 0, 16'h0, 1'b0);
      n_vec++; if (outValid !== 1'b1 || outWord !== 32'hA0000000 || outBits !== 6'd4 || outLast !== 1'b1) begin n_err++; $display("FAIL three_word2: got v=%b %h bits=%0d last=%b want 1 a0000000 4 1", outValid, outWord, outBits, outLast); end
      tick();
      n_vec++; if (flushDone !== 1'b1) begin n_err++; $display("FAIL three_done: got %b want 1", flushDone); end
      tick();
   endtask

   task automatic test_backpressure();
      outReady = 1'b0;
      drive(1'b1, 16, 16'h1234, 1'b0); tick();
      drive(1'b1, 12, 16'h0ABC, 1'b0); tick();
      drive(1'b1, 8, 16'h005E, 1'b0); tick();
      drive(1'b1, 8, 16'h00FF, 1'b0);
      for (int i = 0; i < 10; i++) begin
         n_vec++; if (inReady !== 1'b0 || outValid !== 1'b1 || outWord !== 32'h1234ABC5) begin n_err++; $display("FAIL bp_hold cyc %0d: got rdy=%b v=%b %h want 0 1 1234abc5", i, inReady, outValid, outWord); end
         tick();
      end
      drive(1'b0, 0, 16'h0, 1'b0);
      outReady = 1'b1;
      tick();
      n_vec++; if (inReady !== 1'b1 || outValid !== 1'b0) begin n_err++; $display("FAIL bp_release: got rdy=%b v=%b want 1/0", inReady, outValid); end
      drive(1'b1, 0, 16'h0, 1'b1); tick();
      drive(1'b0, 0, 16'h0, 1'b0);
      n_vec++; if (outValid !== 1'b1 || outWord !== 32'hE0000000 || outBits !== 6'd4 || outLast !== 1'b1) begin n_err++; $display("FAIL bp_residue: got v=%b %h bits=%0d last=%b want 1 e0000000 4 1", outValid, outWord, outBits, outLast); end
      tick(); tick();
   endtask

   task automatic test_flush_only();
      int pulses = 0;
      bit saw_valid = 1'b0;
      outReady = 1'b1;
      drive(1'b1, 0, 16'hFFFF, 1'b1); tick();
      drive(1'b0, 0, 16'h0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         if (flushDone === 1'b1) pulses++;
         if (outValid !== 1'b0) saw_valid = 1'b1;
         tick();
      end
      n_vec++; if (pulses != 1) begin n_err++; $display("FAIL flush_only_pulses: got %0d want 1", pulses); end
      n_vec++; if (saw_valid) begin n_err++; $display("FAIL flush_only_valid: got outValid=1 want none"); end
      n_vec++; if (inReady !== 1'b1) begin n_err++; $display("FAIL flush_only_run: got rdy=%b want 1", inReady); end
   endtask

   task automatic test_reset_mid_flush();
      outReady = 1'b0;
      drive(1'b1, 16, 16'hFFFF, 1'b0); tick();
      drive(1'b1, 4, 16'h0005, 1'b1); tick();
      drive(1'b0, 0, 16'h0, 1'b0);
      n_vec++; if (outValid !== 1'b1 || outLast !== 1'b1 || outBits !== 6'd20) begin n_err++; $display("FAIL rstmid_pre: got v=%b last=%b bits=%0d want 1 1 20", outValid, outLast, outBits); end
      rst_n = 1'b0;
      tick();
      n_vec++; if (outValid !== 1'b0 || outWord !== 32'h0 || inReady !== 1'b0) begin n_err++; $display("FAIL rstmid_out: got v=%b %h rdy=%b want 0 0 0", outValid, outWord, inReady); end
      n_vec++; if (bitCount !== 32'd0) begin n_err++; $display("FAIL rstmid_bitCount: got %0d want 0", bitCount); end
      rst_n = 1'b1;
      outReady = 1'b1;
      #1;
      n_vec++; if (outValid !== 1'b0) begin n_err++; $display("FAIL rstmid_no_last: got v=%b want 0", outValid); end
      drive(1'b1, 8, 16'h00A5, 1'b1); tick();
      drive(1'b0, 0, 16'h0, 1'b0);
      n_vec++; if (outValid !== 1'b1 || outWord !== 32'hA5000000 || outBits !== 6'd8 || outLast !== 1'b1) begin n_err++; $display("FAIL rstmid_new: got v=%b %h bits=%0d last=%b want 1 a5000000 8 1", outValid, outWord, outBits, outLast); end
      tick();
      n_vec++; if (flushDone !== 1'b1 || bitCount !== 32'd8) begin n_err++; $display("FAIL rstmid_done: got fd=%b bc=%0d want 1 8", flushDone, bitCount); end
      tick();
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         n_vec++; if (inReady !== m_ready()) begin n_err++; $display("FAIL rnd_inReady cyc %0d: got %b want %b", cyc, inReady, m_ready()); end
         n_vec++; if (outValid !== m_valid()) begin n_err++; $display("FAIL rnd_outValid cyc %0d: got %b want %b", cyc, outValid, m_valid()); end
         if (m_valid()) begin
            n_vec++;
            if (outWord !== m_word() || outLast !== m_last() || outBits !== m_bits()) begin
               n_err++;
               $display("FAIL rnd_word cyc %0d: got %h last=%b bits=%0d want %h last=%b bits=%0d",
                        cyc, outWord, outLast, outBits, m_word(), m_last(), m_bits());
            end
         end
         n_vec++; if (bitCount !== m_bitcount) begin n_err++; $display("FAIL rnd_bitCount cyc %0d: got %0d want %0d", cyc, bitCount, m_bitcount); end
         n_vec++; if (flushDone !== m_fd) begin n_err++; $display("FAIL rnd_flushDone cyc %0d: got %b want %b", cyc, flushDone, m_fd); end
         drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 20)), 16'($urandom),
               $urandom_range(0, 15) == 0);
         outReady = $urandom_range(0, 3) != 0;
         tick();
      end
      drive(1'b0, 0, 16'h0, 1'b0);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_eight_beats();
      test_flush_single();
      test_three_beats();
      test_backpressure();
      test_flush_only();
      test_reset_mid_flush();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
